// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared RV32 core definitions: the ALU operation encoding used across the
// execute stage, the state encoding of the iterative divider, and small
// helpers that classify divide/remainder operations.
// ---------------------------------------------------------------------------
package rv32_pkg;

    // ALU operation select, shared by every execute-stage unit
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    // Iterative divider sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // True for the four operations the divider acts on
    function automatic logic is_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // True for the two's-complement variants
    function automatic logic is_signed_div_op(input alu_op_e op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // True when the remainder, not the quotient, is the requested result
    function automatic logic is_rem_op(input alu_op_e op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU. Produces one quotient
// bit per cycle (32 CALC cycles), then a sign-fix cycle, then a one-cycle
// DONE pulse. Divide-by-zero and signed overflow bypass the iteration and
// complete in the cycle after the start is sampled.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start_i   in   request to begin a division
//   alu_op_i  in   operation select (alu_op_e)
//   op_a_i    in   dividend
//   op_b_i    in   divisor
//   flush_i   in   abort the current operation
//   busy_o    out  high whenever not IDLE
//   stall_o   out  pipeline hold request
//   done_o    out  one-cycle result-valid pulse
//   result_o  out  quotient or remainder, held until the next completion
// ---------------------------------------------------------------------------
module div_sequencer
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  alu_op_e         alu_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [4:0] CNT_LOAD = 5'd31;

    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q;
    alu_op_e         op_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] result_q;
    logic            quo_neg_q;
    logic            rem_neg_q;

    logic            accept;
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            take;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] fix_quo;
    logic [XLEN-1:0] fix_rem;
    logic [XLEN-1:0] fix_result;

    // Start qualification and operand preparation. Flush blocks a start in
    // the same cycle; signed ops are reduced to magnitudes and the signs are
    // remembered for the FIX cycle.
    always_comb begin
        accept    = (state_q == IDLE) && start_i && !flush_i && is_div_op(alu_op_i);
        signed_op = is_signed_div_op(alu_op_i);
        a_neg     = signed_op && op_a_i[XLEN-1];
        b_neg     = signed_op && op_b_i[XLEN-1];
        abs_a     = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        abs_b     = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        div_zero  = (op_b_i == '0);
        overflow  = signed_op && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
        special   = div_zero || overflow;

        // Divide by zero wins over overflow (overflow needs divisor -1)
        special_result = '0;
        if (div_zero) begin
            special_result = is_rem_op(alu_op_i) ? op_a_i : '1;
        end else if (overflow) begin
            special_result = is_rem_op(alu_op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // One restoring step: the partial remainder is shifted left with the
    // next dividend bit (taken from the top of quo_q, which doubles as the
    // dividend shift register) and the divisor is subtracted in XLEN+1 bits;
    // a clear sign bit means the subtraction fits and the quotient bit is 1.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_q};
        take    = !diff[XLEN];
        rem_nxt = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], take};
    end

    // Sign correction applied in FIX: quotient negated when operand signs
    // differ, remainder takes the sign of the dividend.
    always_comb begin
        fix_quo    = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
        fix_rem    = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
        fix_result = is_rem_op(op_q) ? fix_rem : fix_quo;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Datapath registers. result_q is only written on the way into DONE so
    // it holds across idle periods and is left untouched by a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= ALU_ADD;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept) begin
            cnt_q     <= CNT_LOAD;
            op_q      <= alu_op_i;
            quo_q     <= abs_a;
            rem_q     <= '0;
            dvsr_q    <= abs_b;
            quo_neg_q <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (special) begin
                result_q <= special_result;
            end
        end else if ((state_q == CALC) && !flush_i) begin
            cnt_q <= cnt_q - 5'd1;
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
        end else if ((state_q == FIX) && !flush_i) begin
            result_q <= fix_result;
        end
    end

    // Outputs. Reset forces everything to zero even before the first edge
    // has cleared the registers; stall drops in DONE so the pipeline moves
    // on with the result.
    always_comb begin
        busy_o   = !rst && (state_q != IDLE);
        stall_o  = !rst && (accept || (state_q == CALC) || (state_q == FIX));
        done_o   = !rst && (state_q == DONE);
        result_o = rst ? '0 : result_q;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_div_sequencer
// Directed test of div_sequencer: normal and signed divides, divide by zero,
// signed overflow, ignored starts, flush and reset behaviour. All expected
// values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_div_sequencer;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    alu_op_e     alu_op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    div_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .alu_op_i (alu_op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current cycle (cycle 0), scramble the
    // inputs afterwards, and check latency, result, stall profile and that
    // the result holds after DONE. Optionally pokes a second start mid-CALC.
    task automatic applyStimulus(input alu_op_e op, input logic [31:0] a,
                                 input logic [31:0] b, input int expCycle,
                                 input logic [31:0] expResult, input bit inject,
                                 input string tag);
        int doneCycle  = 0;
        int stallCount = 0;
        start_i  = 1'b1;
        alu_op_i = op;
        op_a_i   = a;
        op_b_i   = b;
        flush_i  = 1'b0;
        #1;
        checkOutput({tag, " stall_start"}, 32'(stall_o), 32'd1);
        nextCycle();
        start_i  = 1'b0;
        alu_op_i = ALU_ADD;
        op_a_i   = 32'hDEAD_BEEF;
        op_b_i   = 32'h0000_0003;
        for (int c = 1; c <= 40; c++) begin
            if (done_o) begin
                doneCycle = c;
                break;
            end
            if (stall_o) stallCount++;
            if (inject && (c == 5)) begin
                start_i  = 1'b1;
                alu_op_i = ALU_DIVU;
                op_a_i   = 32'd50;
                op_b_i   = 32'd5;
            end else begin
                start_i  = 1'b0;
                alu_op_i = ALU_ADD;
            end
            nextCycle();
        end
        start_i = 1'b0;
        checkOutput({tag, " latency"}, 32'(doneCycle), 32'(expCycle));
        checkOutput({tag, " result"}, result_o, expResult);
        checkOutput({tag, " stall_cycles"}, 32'(stallCount), 32'(expCycle - 1));
        checkOutput({tag, " stall_done"}, 32'(stall_o), 32'd0);
        checkOutput({tag, " busy_done"}, 32'(busy_o), 32'd1);
        nextCycle();
        checkOutput({tag, " done_pulse"}, 32'(done_o), 32'd0);
        checkOutput({tag, " busy_after"}, 32'(busy_o), 32'd0);
        checkOutput({tag, " result_hold"}, result_o, expResult);
    endtask

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        int donePulses;
        rst      = 1'b1;
        start_i  = 1'b0;
        flush_i  = 1'b0;
        alu_op_i = ALU_ADD;
        op_a_i   = '0;
        op_b_i   = '0;

        // Reset state, and reset beating a start
        nextCycle();
        nextCycle();
        checkOutput("rst busy", 32'(busy_o), 32'd0);
        checkOutput("rst stall", 32'(stall_o), 32'd0);
        checkOutput("rst done", 32'(done_o), 32'd0);
        checkOutput("rst result", result_o, 32'h0);
        start_i  = 1'b1;
        alu_op_i = ALU_DIVU;
        op_a_i   = 32'd10;
        op_b_i   = 32'd1;
        #1;
        checkOutput("rst stall_start", 32'(stall_o), 32'd0);
        nextCycle();
        checkOutput("rst start_ignored", 32'(busy_o), 32'd0);
        start_i = 1'b0;
        rst     = 1'b0;
        nextCycle();

        // Normal unsigned and signed divides
        applyStimulus(ALU_DIVU, 32'd100, 32'd7, 34, 32'd14, 1'b0, "divu100/7");
        applyStimulus(ALU_REMU, 32'd100, 32'd7, 34, 32'd2, 1'b0, "remu100/7");
        applyStimulus(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 1'b0, "div-7/2");
        applyStimulus(ALU_REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 1'b0, "rem-7/2");
        applyStimulus(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 34, 32'hFFFF_FFF2, 1'b0, "div100/-7");
        applyStimulus(ALU_REM, 32'd100, 32'hFFFF_FFF9, 34, 32'd2, 1'b0, "rem100/-7");

        // Divide by zero and signed overflow shortcuts
        applyStimulus(ALU_DIVU, 32'h1234, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, "divu/0");
        applyStimulus(ALU_REM, 32'h1234, 32'h0, 1, 32'h1234, 1'b0, "rem/0");
        applyStimulus(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0, "div_ovf");
        applyStimulus(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 1'b0, "rem_ovf");

        // Start while busy is ignored
        applyStimulus(ALU_DIVU, 32'd100, 32'd7, 34, 32'd14, 1'b1, "divu_inject");

        // Wide operands exercise the top bit of the subtractor
        applyStimulus(ALU_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 32'd1, 1'b0, "divu_wide");
        applyStimulus(ALU_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 32'd1, 1'b0, "remu_wide");

        // Non-divide op is ignored
        start_i  = 1'b1;
        alu_op_i = ALU_ADD;
        op_a_i   = 32'd5;
        op_b_i   = 32'd5;
        #1;
        checkOutput("add stall", 32'(stall_o), 32'd0);
        nextCycle();
        start_i = 1'b0;
        checkOutput("add busy", 32'(busy_o), 32'd0);
        checkOutput("add result", result_o, 32'd1);

        // Flush wins over a simultaneous start
        start_i  = 1'b1;
        flush_i  = 1'b1;
        alu_op_i = ALU_DIVU;
        op_a_i   = 32'd9;
        op_b_i   = 32'd3;
        #1;
        checkOutput("flushstart stall", 32'(stall_o), 32'd0);
        nextCycle();
        start_i = 1'b0;
        flush_i = 1'b0;
        checkOutput("flushstart busy", 32'(busy_o), 32'd0);

        // Flush in the 10th CALC cycle, then an immediate new divide
        start_i  = 1'b1;
        alu_op_i = ALU_DIVU;
        op_a_i   = 32'd100;
        op_b_i   = 32'd7;
        nextCycle();
        start_i = 1'b0;
        repeat (9) nextCycle();
        checkOutput("flush calc_busy", 32'(busy_o), 32'd1);
        checkOutput("flush calc_stall", 32'(stall_o), 32'd1);
        flush_i = 1'b1;
        nextCycle();
        flush_i = 1'b0;
        checkOutput("flush busy", 32'(busy_o), 32'd0);
        checkOutput("flush done", 32'(done_o), 32'd0);
        checkOutput("flush result", result_o, 32'd1);
        applyStimulus(ALU_DIVU, 32'd9, 32'd3, 34, 32'd3, 1'b0, "divu9/3");

        // Flush during DONE keeps the pulse already on the output
        start_i  = 1'b1;
        alu_op_i = ALU_DIVU;
        op_a_i   = 32'd5;
        op_b_i   = 32'd0;
        nextCycle();
        start_i = 1'b0;
        flush_i = 1'b1;
        #1;
        checkOutput("flushdone done", 32'(done_o), 32'd1);
        checkOutput("flushdone result", result_o, 32'hFFFF_FFFF);
        nextCycle();
        flush_i = 1'b0;
        checkOutput("flushdone busy", 32'(busy_o), 32'd0);

        // Reset mid-CALC discards the operation
        start_i  = 1'b1;
        alu_op_i = ALU_DIVU;
        op_a_i   = 32'd100;
        op_b_i   = 32'd7;
        nextCycle();
        start_i = 1'b0;
        repeat (9) nextCycle();
        rst = 1'b1;
        nextCycle();
        checkOutput("rstcalc busy", 32'(busy_o), 32'd0);
        checkOutput("rstcalc stall", 32'(stall_o), 32'd0);
        checkOutput("rstcalc done", 32'(done_o), 32'd0);
        checkOutput("rstcalc result", result_o, 32'h0);
        rst = 1'b0;
        donePulses = 0;
        for (int c = 0; c < 40; c++) begin
            nextCycle();
            if (done_o) donePulses++;
        end
        checkOutput("rstcalc no_done", 32'(donePulses), 32'd0);
        applyStimulus(ALU_DIVU, 32'd9, 32'd3, 34, 32'd3, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have port start_i  input  1  request to begin a division.
REQ-005 The block SHALL have port alu_op_i  input  alu_op_e (5)  operation select; only ALU_DIV, ALU_DIVU, ALU_REM and ALU_REMU are acted on.
REQ-006 The block SHALL have port op_a_i  input  XLEN  dividend.
REQ-007 The block SHALL have port op_b_i  input  XLEN  divisor.
REQ-008 The block SHALL have port flush_i  input  1  abort the current operation.
REQ-009 The block SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-010 The block SHALL have port stall_o  output  1  pipeline hold request.
REQ-011 The block SHALL have port done_o  output  1  one-cycle result-valid pulse.
REQ-012 The block SHALL have port result_o  output  XLEN  quotient or remainder.

Function
REQ-013 The state machine SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 A start SHALL be accepted only in IDLE with start_i=1, flush_i=0 and alu_op_i a divide or remainder op; all other starts are ignored with no state change.
REQ-015 On acceptance the block SHALL latch op, op_a_i and op_b_i; later input changes SHALL NOT affect the result.
REQ-016 Divisor 0 SHALL go IDLE->DONE with quotient 0xFFFFFFFF and remainder equal to the dividend, for both signed and unsigned ops.
REQ-017 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL go IDLE->DONE with quotient 0x80000000 and remainder 0.
REQ-018 In all other cases, IDLE SHALL go to CALC with the absolute values for signed ops and the raw values for unsigned ops.
REQ-019 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first.
REQ-020 CALC SHALL use a 5-bit counter loaded with 31 that decrements each cycle and SHALL go to FIX after the cycle in which the counter is 0, i.e. exactly 32 CALC cycles.
REQ-021 In FIX, signed ops SHALL negate the quotient when the operand signs differ and SHALL give the remainder the sign of the dividend; unsigned ops pass through; FIX then goes to DONE.
REQ-022 DONE SHALL drive done_o=1 and a valid result_o for exactly one cycle, then return to IDLE.
REQ-023 Latency SHALL be measured from the edge at which start is sampled: the normal path has done_o high in cycle 34, and the REQ-016/REQ-017 special-case path has done_o high in cycle 1.
REQ-024 stall_o SHALL equal (accepted start, combinational) OR state is CALC or FIX, and SHALL be low in DONE so the pipeline advances with the result.
REQ-025 result_o SHALL hold its value after DONE until the next completion.
REQ-026 A start_i while busy SHALL be ignored.
REQ-027 flush_i=1 in any state SHALL force IDLE at the next edge with no done_o pulse and result_o unchanged.
REQ-028 flush_i SHALL take priority over start_i in the same cycle.
REQ-029 A flush in DONE SHALL NOT cancel the done_o already being driven in that cycle.

Reset
REQ-030 With rst=1 at an edge, the block SHALL return to IDLE and clear the counter.
REQ-031 During reset, busy_o, stall_o and done_o SHALL be 0 and result_o SHALL be 0x00000000.
REQ-032 Reset SHALL have priority over flush_i and start_i.
REQ-033 Reset mid-CALC SHALL discard the operation without a done_o pulse.

Structure
REQ-034 The state enum div_state_e SHALL be added to rv32_pkg.
REQ-035 The block SHALL reuse alu_op_e from rv32_pkg; no op encodings SHALL be redefined locally.
REQ-036 The block SHALL be a single module with no sub-module; the datapath is 32-bit quotient and remainder registers plus a 33-bit subtractor.

Verification
REQ-037 The bench SHALL check: DIVU 100/7 -> done_o in cycle 34, result 14; REMU 100/7 -> result 2.
REQ-038 The bench SHALL check: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
REQ-039 The bench SHALL check: DIVU 0x1234/0 -> 0xFFFFFFFF in cycle 1; REM 0x1234/0 -> 0x1234; stall_o high only in the start cycle.
REQ-040 The bench SHALL check: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-041 The bench SHALL check: flush_i in the 10th CALC cycle -> IDLE at the next edge, no done_o, and an immediately following DIVU 9/3 -> 3 after 34 cycles.
REQ-042 The bench SHALL check: start_i with ALU_ADD, or start_i during CALC -> ignored, with busy_o and the result unaffected; rst mid-CALC -> all outputs 0 on the next cycle.
